apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator: converts a simple valid/ready command stream into APB3 transfers on PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns PRDATA/PSLVERR on a valid/ready response stream.
- Sits on the testbench/host side of the APB bus and drives the APB-to-SPI slave.
- Also registers the slave's interrupt line for the host.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with APB_MASTER_TIMEOUT_EN.

Ports:
- PCLK  input  1  clock; all logic on its rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  bridge can accept a command.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  host accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_slverr  output  1  PSLVERR captured, or timeout.
- rsp_timeout  output  1  transfer aborted by the watchdog.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.
- interrupt  input  1  slave interrupt.
- irq_o  output  1  interrupt registered by one cycle.

Behaviour:
- Clocking/reset: single clock PCLK. PRESET is asynchronous and active-high.
- Reset values:
  - state=IDLE; cmd_ready=1.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid, rsp_slverr, rsp_timeout, irq_o = 0; rsp_rdata = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. cmd_ready = (state==IDLE); no command is accepted in any other state.
- IDLE:
  - On cmd_valid&&cmd_ready, register cmd_write, cmd_wdata and cmd_addr into PWRITE/PWDATA/PADDR.
  - PADDR[1:0] is forced to 0 (word-aligned) when DATA_WIDTH=32.
  - Next state SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle; next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - Stay while PREADY=0; each such cycle is a wait state.
  - On PREADY=1, capture rsp_rdata=PRDATA for reads (0 for writes) and rsp_slverr=PSLVERR.
  - Assert rsp_valid, deassert PSEL/PENABLE on the same edge, next state RESP.
- RESP:
  - rsp_valid held, with rsp_rdata/rsp_slverr/rsp_timeout stable, until rsp_ready=1.
  - On handshake: rsp_valid=0 and next state IDLE.
- Signal sampling:
  - PREADY and PSLVERR are ignored outside ACCESS.
  - PRDATA is sampled only on the completing ACCESS cycle.
- Address/data hold:
  - PADDR/PWRITE/PWDATA remain constant from SETUP through ACCESS completion.
  - They keep their last values while idle; they are not zeroed.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2. With PREADY=1 in N+2, rsp_valid is high in N+3. With rsp_ready=1, cmd_ready is high again in N+4. Minimum 4 cycles per transfer; one wait state adds one cycle.
- Pipelining: transfers are strictly sequential; only one transfer is ever outstanding.
- Reset mid-transfer: PSEL/PENABLE/rsp_valid drop immediately and asynchronously. The transfer is lost and no response is issued.
- Interrupt: irq_o <= interrupt every cycle.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL/PENABLE go to 0, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, next state RESP.
  - PREADY=1 on the same cycle the count reaches the limit wins: normal completion, rsp_timeout=0.
- Disabled: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

Test Plan:
- Write addr=0x04, wdata=0xA5A5_0001, PREADY=1 immediately → one SETUP cycle (PSEL=1, PENABLE=0), one ACCESS cycle. Response rsp_slverr=0, rsp_rdata=0. cmd_ready high 4 cycles after acceptance.
- Read addr=0x08, PREADY low for 3 ACCESS cycles, then PRDATA=0x0000_00C3 → PADDR/PWRITE stable for all 4 ACCESS cycles. rsp_rdata=0xC3.
- Read with PREADY=1 and PSLVERR=1 → rsp_slverr=1. A PSLVERR pulse while in IDLE or SETUP is ignored.
- Hold rsp_ready=0 for 5 cycles, with cmd_valid=1 and a second command pending → rsp_valid and data stay stable, cmd_ready stays 0. The second command starts only after the response handshake. Back-to-back transfers never overlap.
- Assert PRESET during ACCESS → PSEL/PENABLE go to 0 without waiting for PCLK. No rsp_valid is issued. Next command completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold PREADY=0 → abort after 8 ACCESS cycles with rsp_slverr=1, rsp_timeout=1. Without the macro, the bus is still in ACCESS after 300 cycles.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB3 initiator: valid/ready command stream in, APB transfer out, response stream back.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  interrupt,
  output logic                  irq_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    (DATA_WIDTH == 32) ? {{(ADDR_WIDTH-2){1'b1}}, 2'b00} : '1;

  state_t state, state_next;
  logic   accept;
  logic   timeout_hit;
  logic   complete;

  assign accept   = cmd_valid && (state == IDLE);
  assign complete = (state == ACCESS) && (PREADY || timeout_hit);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  // Bus controls decode straight from state so a reset drops them without a clock.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        PSEL       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (complete) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      irq_o <= interrupt;
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr & ADDR_MASK;
        PWDATA <= cmd_wdata;
      end
      if ((state == ACCESS) && PREADY) begin
        rsp_rdata  <= PWRITE ? '0 : PRDATA;
        rsp_slverr <= PSLVERR;
      end else if (timeout_hit) begin
        rsp_rdata  <= '0;
        rsp_slverr <= 1'b1;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  // Abort on the edge where the count would reach the limit; PREADY on that cycle wins.
  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = timeout_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == SETUP)                    wait_cnt <= '0;
      else if ((state == ACCESS) && !PREADY) wait_cnt <= wait_cnt + 1'b1;
      if (complete) timeout_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a small APB slave model and response scoreboard.
module tb_apb_master_bridge;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 256;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        interrupt, irq_o;

  int          slv_wait;
  logic [31:0] slv_rdata;
  logic        slv_err;
  int          acc_cnt;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  always #5 PCLK = ~PCLK;

  // Slave: PREADY after slv_wait wait states; PRDATA is junk except on the ready cycle.
  assign PREADY  = PSEL && PENABLE && (acc_cnt >= slv_wait);
  assign PRDATA  = PREADY ? slv_rdata : 32'hDEAD_BEEF;
  assign PSLVERR = slv_err;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                           acc_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY)  acc_cnt <= acc_cnt + 1;
    else                                  acc_cnt <= 0;
  end

  apb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .interrupt(interrupt), .irq_o(irq_o)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Drives one command until accepted, then waits (bounded) for rsp_valid.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output bit ok);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    ok = rsp_valid;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; interrupt = 1'b1;
    #3;
    checks++;
    if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout, irq_o} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 10000000",
               {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout, irq_o});
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {PADDR, PWDATA, rsp_rdata});
    end
    tick(); tick();
    PRESET = 1'b0; interrupt = 1'b0;
    tick();
  endtask

  task automatic test_irq();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq_o); end
    tick();
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq_o); end
  endtask

  task automatic test_write();
    rsp_t e, got;
    slv_wait = 0; slv_err = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    cmd_write = 1'b1; cmd_addr = 32'h04; cmd_wdata = 32'hA5A5_0001; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({PSEL, PENABLE, cmd_ready} !== 3'b100) begin
      errors++; $display("FAIL write_setup got %b exp 100", {PSEL, PENABLE, cmd_ready});
    end
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 32'h04, 32'hA5A5_0001}) begin
      errors++; $display("FAIL write_access got %h exp %h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                         {3'b111, 32'h04, 32'hA5A5_0001});
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin
      errors++; $display("FAIL write_resp_phase got %b exp 100", {rsp_valid, PSEL, PENABLE});
    end
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL write_rsp got %h exp %h", got, e); end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL write_latency got %b exp 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_read_wait();
    rsp_t e, got;
    slv_wait = 3; slv_rdata = 32'h0000_00C3; slv_err = 1'b0;
    exp_q.push_back('{rdata: 32'hC3, err: 1'b0, to: 1'b0});
    cmd_write = 1'b0; cmd_addr = 32'h08; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b110, 32'h08}) begin
        errors++; $display("FAIL read_hold cycle %0d got %h exp %h", i, {PSEL, PENABLE, PWRITE, PADDR},
                           {3'b110, 32'h08});
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read_wait_done got %b exp 1", rsp_valid); end
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL read_rsp got %h exp %h", got, e); end
    ack();
  endtask

  task automatic test_slverr();
    rsp_t e, got;
    bit ok;
    slv_wait = 0; slv_rdata = 32'h0000_005A;
    slv_err = 1'b1; tick(); slv_err = 1'b0;
    exp_q.push_back('{rdata: 32'h5A, err: 1'b0, to: 1'b0});
    cmd_write = 1'b0; cmd_addr = 32'h13; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    slv_err = 1'b1;
    checks++;
    if (PADDR !== 32'h10) begin errors++; $display("FAIL addr_align got %h exp 00000010", PADDR); end
    tick();
    slv_err = 1'b0;
    tick();
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if ((got !== e) || !rsp_valid) begin
      errors++; $display("FAIL slverr_ignored got %h v=%b exp %h", got, rsp_valid, e);
    end
    ack();
    slv_err = 1'b1; slv_rdata = 32'h0000_0066;
    exp_q.push_back('{rdata: 32'h66, err: 1'b1, to: 1'b0});
    xfer(1'b0, 32'h30, 32'h0, ok);
    slv_err = 1'b0;
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (!ok || (got !== e)) begin errors++; $display("FAIL slverr_rsp got %h ok=%b exp %h", got, ok, e); end
    ack();
  endtask

  task automatic test_back_to_back();
    rsp_t e, got;
    bit ok;
    slv_wait = 0; slv_rdata = 32'h1234_5678;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0});
    xfer(1'b1, 32'h20, 32'h0000_0011, ok);
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (!ok || (got !== e)) begin errors++; $display("FAIL b2b_first got %h ok=%b exp %h", got, ok, e); end
    cmd_write = 1'b0; cmd_addr = 32'h24; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, PSEL, rsp_rdata, rsp_slverr, PADDR} !== {3'b100, 32'h0, 1'b0, 32'h20}) begin
        errors++; $display("FAIL stall cycle %0d got %h exp %h", i,
                           {rsp_valid, cmd_ready, PSEL, rsp_rdata, rsp_slverr, PADDR},
                           {3'b100, 32'h0, 1'b0, 32'h20});
      end
      tick();
    end
    ack();
    checks++;
    if ({cmd_ready, PSEL} !== 2'b10) begin
      errors++; $display("FAIL b2b_idle got %b exp 10", {cmd_ready, PSEL});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 32'h24}) begin
      errors++; $display("FAIL b2b_second_setup got %h exp %h", {PSEL, PENABLE, PADDR}, {2'b10, 32'h24});
    end
    tick(); tick();
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (!rsp_valid || (got !== e)) begin
      errors++; $display("FAIL b2b_second got %h v=%b exp %h", got, rsp_valid, e);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    rsp_t e, got;
    bit ok, stray;
    slv_wait = 1000;
    cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hFFFF_0000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL async_reset got %b exp 000", {PSEL, PENABLE, rsp_valid});
    end
    #1 PRESET = 1'b0;
    slv_wait = 0;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid || !cmd_ready) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL lost_xfer_rsp got %b exp 0", stray); end
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    xfer(1'b1, 32'h44, 32'h0000_BEEF, ok);
    got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
    e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (!ok || (got !== e)) begin errors++; $display("FAIL post_reset_xfer got %h ok=%b exp %h", got, ok, e); end
    ack();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    rsp_t e, got;
    int n;
    for (int k = 0; k < 2; k++) begin
      slv_wait = (k == 0) ? 1000 : 7;
      slv_rdata = 32'h0000_0077;
      if (k == 0) exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
      else        exp_q.push_back('{rdata: 32'h77, err: 1'b0, to: 1'b0});
      cmd_write = 1'b0; cmd_addr = 32'h50; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      n = 0;
      while (PSEL && PENABLE && n < 50) begin tick(); n++; end
      checks++;
      if (n !== 8) begin errors++; $display("FAIL timeout_len case %0d got %0d exp 8", k, n); end
      got = '{rdata: rsp_rdata, err: rsp_slverr, to: rsp_timeout};
      e = '1; if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++;
      if (!rsp_valid || (got !== e)) begin
        errors++; $display("FAIL timeout_rsp case %0d got %h v=%b exp %h", k, got, rsp_valid, e);
      end
      ack();
    end
  endtask
`else
  task automatic test_timeout();
    slv_wait = 100000;
    cmd_write = 1'b0; cmd_addr = 32'h50; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    repeat (300) tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid, rsp_timeout} !== 4'b1100) begin
      errors++; $display("FAIL no_timeout got %b exp 1100", {PSEL, PENABLE, rsp_valid, rsp_timeout});
    end
    #2 PRESET = 1'b1;
    #2 PRESET = 1'b0;
    slv_wait = 0;
    tick();
  endtask
`endif

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; interrupt = 1'b0;
    slv_wait = 0; slv_rdata = '0; slv_err = 1'b0;
    test_reset();
    test_irq();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
